// File: rtl/neureka_infeat_pingpong_buffer.sv
// NEUREKA input-feature ping-pong buffer: one bank fills from the stream
// while the other is presented whole to the window extractor.
module neureka_infeat_pingpong_buffer #(
  parameter int NUM_WORDS  = 64,
  parameter int BLOCK_SIZE = 32,
  parameter int DW         = 8,
  parameter int BUF_W      = 8,
  parameter int PE_W       = 6,
  parameter int LW         = $clog2(NUM_WORDS+1)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               load_start_i,
  input  logic [LW-1:0]                      load_len_i,
  input  logic                               mode_1x1_i,
  input  logic                               broadcast_i,
  input  logic [NUM_WORDS-1:0]               pad_implicit_i,
  input  logic [NUM_WORDS-1:0]               pad_explicit_i,
  input  logic [DW-1:0]                      pad_value_lo_i,
  input  logic [DW-1:0]                      pad_value_hi_i,
  input  logic                               feat_valid_i,
  output logic                               feat_ready_o,
  input  logic [BLOCK_SIZE*DW-1:0]           feat_data_i,
  output logic                               out_valid_o,
  output logic [NUM_WORDS*BLOCK_SIZE*DW-1:0] out_data_o,
  input  logic                               release_i,
  output logic [1:0]                         bank_full_o,
  output logic [1:0]                         state_o
);

  localparam int WW = BLOCK_SIZE*DW;
  localparam int IW = $clog2(NUM_WORDS);
  localparam int AW = LW + $clog2(BUF_W) + 1;

  localparam logic [1:0] LD_IDLE = 2'd0;
  localparam logic [1:0] LD_WAIT = 2'd1;
  localparam logic [1:0] LD_LOAD = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 wr_q, wr_d;
  logic                 rd_q, rd_d;
  logic [1:0]           full_q, full_d;
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 m1_q, m1_d;
  logic                 bc_q, bc_d;
  logic [NUM_WORDS-1:0] pimp_q, pimp_d;
  logic [NUM_WORDS-1:0] pexp_q, pexp_d;
  logic [DW-1:0]        plo_q, plo_d;
  logic [DW-1:0]        phi_q, phi_d;

  logic [WW-1:0] bank_q [2][NUM_WORDS];

  logic          beat;
  logic          last;
  logic          in_rng;
  logic [IW-1:0] waddr;
  logic [AW-1:0] addr_nxt;
  logic [WW-1:0] wdata;

  assign feat_ready_o = (state_q == LD_LOAD);
  assign beat         = feat_valid_i & feat_ready_o;
  assign last         = beat && (cnt_q == len_q - 1'b1);
  assign in_rng       = (addr_q < AW'(NUM_WORDS));
  assign waddr        = addr_q[IW-1:0];

  // 1x1 mode skips the unused tail of each buffer row
  assign addr_nxt = (m1_q && ((addr_q % AW'(BUF_W)) == AW'(PE_W-1)))
                  ? addr_q + AW'(BUF_W-PE_W+1)
                  : addr_q + 1'b1;

  always_comb begin
    wdata = '0;
    for (int c = 0; c < BLOCK_SIZE; c++) begin
      if (pimp_q[waddr])
        wdata[c*DW +: DW] = '0;
      else if (pexp_q[waddr])
        wdata[c*DW +: DW] = (c % 2 == 1) ? phi_q : plo_q;
      else if (bc_q)
        wdata[c*DW +: DW] = feat_data_i[DW-1:0];
      else
        wdata[c*DW +: DW] = feat_data_i[c*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    m1_d    = m1_q;
    bc_d    = bc_q;
    pimp_d  = pimp_q;
    pexp_d  = pexp_q;
    plo_d   = plo_q;
    phi_d   = phi_q;
    case (state_q)
      LD_IDLE: begin
        if (load_start_i && load_len_i != '0) begin
          len_d   = load_len_i;
          m1_d    = mode_1x1_i;
          bc_d    = broadcast_i;
          pimp_d  = pad_implicit_i;
          pexp_d  = pad_explicit_i;
          plo_d   = pad_value_lo_i;
          phi_d   = pad_value_hi_i;
          state_d = full_q[wr_q] ? LD_WAIT : LD_LOAD;
        end
      end
      LD_WAIT: begin
        if (!full_q[wr_q]) state_d = LD_LOAD;
      end
      LD_LOAD: begin
        if (last) begin
          full_d[wr_q] = 1'b1;
          wr_d         = ~wr_q;
          state_d      = LD_IDLE;
          cnt_d        = '0;
          addr_d       = '0;
        end else if (beat) begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_nxt;
        end
      end
      default: state_d = LD_IDLE;
    endcase
    // a writable bank is never full, so this never collides with the load
    if (release_i && full_q[rd_q]) begin
      full_d[rd_q] = 1'b0;
      rd_d         = ~rd_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LD_IDLE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      full_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      m1_q    <= 1'b0;
      bc_q    <= 1'b0;
      pimp_q  <= '0;
      pexp_q  <= '0;
      plo_q   <= '0;
      phi_q   <= '0;
    end else if (clear_i) begin
      state_q <= LD_IDLE;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      full_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      m1_q    <= 1'b0;
      bc_q    <= 1'b0;
      pimp_q  <= '0;
      pexp_q  <= '0;
      plo_q   <= '0;
      phi_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      m1_q    <= m1_d;
      bc_q    <= bc_d;
      pimp_q  <= pimp_d;
      pexp_q  <= pexp_d;
      plo_q   <= plo_d;
      phi_q   <= phi_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < NUM_WORDS; w++)
          bank_q[b][w] <= '0;
    end else if (clear_i) begin
      for (int b = 0; b < 2; b++)
        for (int w = 0; w < NUM_WORDS; w++)
          bank_q[b][w] <= '0;
    end else if (beat && in_rng) begin
      bank_q[wr_q][waddr] <= wdata;
    end
  end

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_out
    assign out_data_o[w*WW +: WW] = bank_q[rd_q][w];
  end

  assign out_valid_o = full_q[rd_q];
  assign bank_full_o = full_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_neureka_infeat_pingpong_buffer.sv
// Scoreboard bench for the input-feature ping-pong buffer: bank images
// are queued when a load completes and compared when presented.
module tb_neureka_infeat_pingpong_buffer;

  localparam int NUM_WORDS  = 64;
  localparam int BLOCK_SIZE = 32;
  localparam int DW         = 8;
  localparam int BUF_W      = 8;
  localparam int PE_W       = 6;
  localparam int LW         = $clog2(NUM_WORDS+1);
  localparam int WW         = BLOCK_SIZE*DW;
  localparam int OW         = NUM_WORDS*WW;

  logic                 clk = 0;
  logic                 rst = 0;
  logic                 clear_i = 0;
  logic                 load_start_i = 0;
  logic [LW-1:0]        load_len_i = '0;
  logic                 mode_1x1_i = 0;
  logic                 broadcast_i = 0;
  logic [NUM_WORDS-1:0] pad_implicit_i = '0;
  logic [NUM_WORDS-1:0] pad_explicit_i = '0;
  logic [DW-1:0]        pad_value_lo_i = '0;
  logic [DW-1:0]        pad_value_hi_i = '0;
  logic                 feat_valid_i = 0;
  logic                 feat_ready_o;
  logic [WW-1:0]        feat_data_i = '0;
  logic                 out_valid_o;
  logic [OW-1:0]        out_data_o;
  logic                 release_i = 0;
  logic [1:0]           bank_full_o;
  logic [1:0]           state_o;

  neureka_infeat_pingpong_buffer #(
    .NUM_WORDS(NUM_WORDS), .BLOCK_SIZE(BLOCK_SIZE), .DW(DW),
    .BUF_W(BUF_W), .PE_W(PE_W), .LW(LW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear_i),
    .load_start_i(load_start_i), .load_len_i(load_len_i),
    .mode_1x1_i(mode_1x1_i), .broadcast_i(broadcast_i),
    .pad_implicit_i(pad_implicit_i), .pad_explicit_i(pad_explicit_i),
    .pad_value_lo_i(pad_value_lo_i), .pad_value_hi_i(pad_value_hi_i),
    .feat_valid_i(feat_valid_i), .feat_ready_o(feat_ready_o),
    .feat_data_i(feat_data_i), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .release_i(release_i),
    .bank_full_o(bank_full_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0]        mb [2][NUM_WORDS];
  logic                 mwr;
  logic [OW-1:0]        sb [$];
  int                   cur_b;
  int                   cur_len;
  bit                   c_m1, c_bc, rnd;
  logic [NUM_WORDS-1:0] c_pimp, c_pexp;
  logic [DW-1:0]        c_lo, c_hi;
  logic [WW-1:0]        aw6;
  logic [WW-1:0]        pat4;

  task automatic chk(input string tag, input logic [WW-1:0] got,
                     input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < NUM_WORDS; w++)
        mb[b][w] = '0;
    mwr = 1'b0;
    sb.delete();
  endtask

  function automatic logic [WW-1:0] gen(input int b);
    logic [WW-1:0] d;
    for (int c = 0; c < BLOCK_SIZE; c++)
      d[c*DW +: DW] = rnd ? DW'($urandom) : DW'(b + c*5);
    return d;
  endfunction

  task automatic model_write(input int b, input logic [WW-1:0] d);
    int a;
    logic [WW-1:0] wv;
    a = c_m1 ? (b / PE_W) * BUF_W + (b % PE_W) : b;
    if (a < NUM_WORDS) begin
      for (int c = 0; c < BLOCK_SIZE; c++) begin
        if (c_pimp[a])      wv[c*DW +: DW] = '0;
        else if (c_pexp[a]) wv[c*DW +: DW] = (c % 2 == 1) ? c_hi : c_lo;
        else if (c_bc)      wv[c*DW +: DW] = d[DW-1:0];
        else                wv[c*DW +: DW] = d[c*DW +: DW];
      end
      mb[mwr][a] = wv;
    end
  endtask

  task automatic start_load(input int len, input bit m1, input bit bc,
                            input logic [NUM_WORDS-1:0] pi,
                            input logic [NUM_WORDS-1:0] pe,
                            input logic [DW-1:0] lo, input logic [DW-1:0] hi);
    load_start_i   = 1;
    load_len_i     = LW'(len);
    mode_1x1_i     = m1;
    broadcast_i    = bc;
    pad_implicit_i = pi;
    pad_explicit_i = pe;
    pad_value_lo_i = lo;
    pad_value_hi_i = hi;
    cur_len = len; cur_b = 0;
    c_m1 = m1; c_bc = bc; c_pimp = pi; c_pexp = pe; c_lo = lo; c_hi = hi;
    @(posedge clk); #1;
    load_start_i   = 0;
    pad_implicit_i = '0;
    pad_explicit_i = '0;
  endtask

  task automatic feed(input int n, input bit rel_last);
    int done;
    int guard;
    bit rdy;
    logic [WW-1:0] d;
    logic [OW-1:0] img;
    done = 0; guard = 0;
    while (done < n) begin
      d = gen(cur_b);
      feat_valid_i = 1;
      feat_data_i  = d;
      rdy = feat_ready_o;
      if (rel_last && rdy && cur_b == cur_len - 1) release_i = 1;
      @(posedge clk);
      if (rdy) begin
        model_write(cur_b, d);
        cur_b++; done++;
        if (cur_b == cur_len) begin
          for (int w = 0; w < NUM_WORDS; w++) img[w*WW +: WW] = mb[mwr][w];
          sb.push_back(img);
          mwr = ~mwr;
        end
      end
      #1;
      release_i = 0;
      guard++;
      if (guard > n + 40) begin
        chk("feed_timeout", 0, 1);
        break;
      end
    end
    feat_valid_i = 0;
  endtask

  task automatic check_front(input string tag);
    logic [OW-1:0] img;
    chk({tag, "_valid"}, WW'(out_valid_o), 1);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      img = sb.pop_front();
      for (int w = 0; w < NUM_WORDS; w++)
        chk($sformatf("%s_w%0d", tag, w), out_data_o[w*WW +: WW],
            img[w*WW +: WW]);
    end
  endtask

  task automatic rel();
    release_i = 1;
    @(posedge clk); #1;
    release_i = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, WW'(feat_ready_o), 0);
    chk({tag, "_valid"}, WW'(out_valid_o), 0);
    chk({tag, "_state"}, WW'(state_o), 0);
    chk({tag, "_full"},  WW'(bank_full_o), 0);
    chk({tag, "_data"},  WW'(|out_data_o), 0);
  endtask

  initial begin
    model_reset();
    rnd = 0;
    rst = 1;
    #12;
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;

    // linear load, incrementing data
    start_load(64, 0, 0, '0, '0, '0, '0);
    chk("lin_ready_first", WW'(feat_ready_o), 1);
    feed(63, 0);
    chk("lin_valid_pre", WW'(out_valid_o), 0);
    feed(1, 0);
    chk("lin_valid_rise", WW'(out_valid_o), 1);
    chk("lin_full", WW'(bank_full_o), 2'b01);
    aw6 = mb[0][6];
    check_front("A");
    rel();
    chk("lin_valid_fall", WW'(out_valid_o), 0);

    // random linear load into bank1
    rnd = 1;
    start_load(64, 0, 0, '0, '0, '0, '0);
    feed(64, 0);
    check_front("B");
    rel();

    // 1x1 load into bank0, rows keep old tails
    start_load(36, 1, 0, '0, '0, '0, '0);
    feed(35, 0);
    chk("m1_valid_pre", WW'(out_valid_o), 0);
    feed(1, 0);
    chk("m1_valid_rise", WW'(out_valid_o), 1);
    chk("m1_word6_kept", out_data_o[6*WW +: WW], aw6);
    check_front("C");
    rel();

    // padding and broadcast
    start_load(64, 0, 1, 64'h8, 64'h10, 8'h11, 8'h22);
    feed(64, 0);
    pat4 = {16{16'h2211}};
    chk("pad_impl_w3", out_data_o[3*WW +: WW], '0);
    chk("pad_expl_w4", out_data_o[4*WW +: WW], pat4);
    check_front("P");
    rel();

    // ping-pong with stall, then same-cycle final beat and release
    rnd = 0;
    start_load(8, 0, 0, '0, '0, '0, '0);
    feed(8, 0);
    rnd = 1;
    start_load(8, 0, 0, '0, '0, '0, '0);
    feed(8, 0);
    chk("pp_full11", WW'(bank_full_o), 2'b11);
    start_load(8, 0, 0, '0, '0, '0, '0);
    chk("pp_wait_state", WW'(state_o), 1);
    chk("pp_wait_ready", WW'(feat_ready_o), 0);
    check_front("D");
    rel();
    chk("pp_still_wait", WW'(state_o), 1);
    chk("pp_valid_other", WW'(out_valid_o), 1);
    @(posedge clk); #1;
    chk("pp_load_state", WW'(state_o), 2);
    chk("pp_load_ready", WW'(feat_ready_o), 1);
    check_front("E");
    feed(8, 1);
    chk("sim_full", WW'(bank_full_o), 2'b01);
    chk("sim_valid", WW'(out_valid_o), 1);
    chk("sim_state", WW'(state_o), 0);
    check_front("F");
    rel();
    chk("sim_valid_fall", WW'(out_valid_o), 0);

    // async reset in the middle of a load
    start_load(64, 0, 0, '0, '0, '0, '0);
    feed(64, 0);
    start_load(64, 0, 0, '0, '0, '0, '0);
    feed(20, 0);
    chk("prerst_valid", WW'(out_valid_o), 1);
    #2 rst = 1;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    @(posedge clk); #1;

    // synchronous clear in the middle of a load
    start_load(64, 0, 0, '0, '0, '0, '0);
    feed(64, 0);
    start_load(64, 0, 0, '0, '0, '0, '0);
    feed(5, 0);
    clear_i = 1;
    #1;
    chk("clr_sync_valid", WW'(out_valid_o), 1);
    @(posedge clk); #1;
    clear_i = 0;
    chk_zero("clear");
    model_reset();

    // load after clear behaves like the first one
    rnd = 0;
    start_load(64, 0, 0, '0, '0, '0, '0);
    feed(63, 0);
    chk("post_valid_pre", WW'(out_valid_o), 0);
    feed(1, 0);
    chk("post_valid_rise", WW'(out_valid_o), 1);
    check_front("Z");
    rel();
    chk("post_valid_fall", WW'(out_valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
